// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap/mret sequencer: accepts exceptions, interrupts and mret in IDLE,
// then issues one CSR controller-write cycle and one redirect/flush cycle.
module csr_trap_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pc_i,
    input  logic              ecall_i,
    input  logic              ebreak_i,
    input  logic              mret_i,
    input  logic              ext_int_i,
    input  logic              timer_int_i,
    input  logic [DATA_W-1:0] r_mstatus_i,
    input  logic [DATA_W-1:0] r_mepc_i,
    input  logic [DATA_W-1:0] r_mtvec_i,
    input  logic [DATA_W-1:0] r_mie_i,
    output logic              w_enable_o,
    output logic              w_ctrl_enable_o,
    output logic [DATA_W-1:0] w_mstatus_o,
    output logic [DATA_W-1:0] w_mepc_o,
    output logic [DATA_W-1:0] w_mie_o,
    output logic              hold_o,
    output logic              flush_o,
    output logic              jump_en_o,
    output logic [DATA_W-1:0] jump_addr_o,
    output logic [DATA_W-1:0] mcause_o,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAVE    = 2'd1,
        RESTORE = 2'd2,
        JUMP    = 2'd3
    } state_t;

    localparam logic [DATA_W-1:0] CAUSE_ECALL  = DATA_W'(11);
    localparam logic [DATA_W-1:0] CAUSE_EBREAK = DATA_W'(3);
    localparam logic [DATA_W-1:0] CAUSE_EXT    = {1'b1, {(DATA_W-5){1'b0}}, 4'hB};
    localparam logic [DATA_W-1:0] CAUSE_TIMER  = {1'b1, {(DATA_W-5){1'b0}}, 4'h7};

    state_t            state_q, state_d;
    logic              from_mret_q;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] mcause_q;

    logic              in_idle;
    logic              ext_pend, tmr_pend;
    logic              trap_take, mret_take;
    logic [DATA_W-1:0] cause_d;

    // Interrupts are level-sensitive and never latched: they qualify only while enabled.
    assign ext_pend = ext_int_i   & r_mstatus_i[3] & r_mie_i[11];
    assign tmr_pend = timer_int_i & r_mstatus_i[3] & r_mie_i[7];
    assign in_idle  = (state_q == IDLE) && !rst;

    assign trap_take = in_idle & (ecall_i | ebreak_i | (!mret_i & (ext_pend | tmr_pend)));
    assign mret_take = in_idle & !ecall_i & !ebreak_i & mret_i;

    always_comb begin
        cause_d = CAUSE_TIMER;
        if (ecall_i)       cause_d = CAUSE_ECALL;
        else if (ebreak_i) cause_d = CAUSE_EBREAK;
        else if (ext_pend) cause_d = CAUSE_EXT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            from_mret_q <= 1'b0;
            pc_q        <= '0;
            mcause_q    <= '0;
        end else begin
            state_q <= state_d;
            if (trap_take) begin
                pc_q        <= pc_i;
                mcause_q    <= cause_d;
                from_mret_q <= 1'b0;
            end else if (mret_take) begin
                from_mret_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        w_enable_o      = 1'b0;
        w_ctrl_enable_o = 1'b0;
        w_mstatus_o     = '0;
        w_mepc_o        = '0;
        w_mie_o         = '0;
        flush_o         = 1'b0;
        jump_en_o       = 1'b0;
        jump_addr_o     = '0;
        unique case (state_q)
            IDLE: begin
                if (trap_take)      state_d = SAVE;
                else if (mret_take) state_d = RESTORE;
            end
            SAVE: begin
                w_enable_o      = 1'b1;
                w_ctrl_enable_o = 1'b1;
                w_mepc_o        = pc_q;
                w_mie_o         = r_mie_i;
                w_mstatus_o     = r_mstatus_i;
                w_mstatus_o[7]  = r_mstatus_i[3];
                w_mstatus_o[3]  = 1'b0;
                state_d         = JUMP;
            end
            RESTORE: begin
                w_enable_o      = 1'b1;
                w_ctrl_enable_o = 1'b1;
                w_mepc_o        = r_mepc_i;
                w_mie_o         = r_mie_i;
                w_mstatus_o     = r_mstatus_i;
                w_mstatus_o[3]  = r_mstatus_i[7];
                w_mstatus_o[7]  = 1'b1;
                state_d         = JUMP;
            end
            JUMP: begin
                jump_en_o   = 1'b1;
                flush_o     = 1'b1;
                jump_addr_o = from_mret_q ? r_mepc_i : {r_mtvec_i[DATA_W-1:2], 2'b00};
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign hold_o   = trap_take | mret_take | (state_q != IDLE);
    assign mcause_o = mcause_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Table-driven bench for csr_trap_ctrl: one record per cycle, expectations queued on
// drive and compared at the following falling edge, plus an async-reset abort sequence.
module tb_csr_trap_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] pc_i = '0;
    logic         ecall_i = 1'b0, ebreak_i = 1'b0, mret_i = 1'b0;
    logic         ext_int_i = 1'b0, timer_int_i = 1'b0;
    logic [W-1:0] r_mstatus_i = '0, r_mepc_i = '0, r_mtvec_i = '0, r_mie_i = '0;
    logic         w_enable_o, w_ctrl_enable_o, hold_o, flush_o, jump_en_o;
    logic [W-1:0] w_mstatus_o, w_mepc_o, w_mie_o, jump_addr_o, mcause_o;
    logic [1:0]   dbg_state;

    csr_trap_ctrl #(.DATA_W(W)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i),
        .ecall_i(ecall_i), .ebreak_i(ebreak_i), .mret_i(mret_i),
        .ext_int_i(ext_int_i), .timer_int_i(timer_int_i),
        .r_mstatus_i(r_mstatus_i), .r_mepc_i(r_mepc_i), .r_mtvec_i(r_mtvec_i), .r_mie_i(r_mie_i),
        .w_enable_o(w_enable_o), .w_ctrl_enable_o(w_ctrl_enable_o),
        .w_mstatus_o(w_mstatus_o), .w_mepc_o(w_mepc_o), .w_mie_o(w_mie_o),
        .hold_o(hold_o), .flush_o(flush_o), .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o),
        .mcause_o(mcause_o), .state_o(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic         hold, wen, wctrl, jump, flush;
        logic [W-1:0] wms, wmepc, wmie, jaddr, mc;
    } out_t;
    localparam int OUT_W = $bits(out_t);

    typedef struct {
        string        name;
        logic         rst;
        logic [4:0]   req;   // {ecall, ebreak, mret, ext, timer}
        logic [W-1:0] pc, ms, mepc, mtvec, mie;
        out_t         exp;
    } vec_t;

    localparam logic [4:0] R0 = 5'b00000, R_EC = 5'b10000, R_EB = 5'b01000,
                           R_MR = 5'b00100, R_EX = 5'b00010, R_TM = 5'b00001;
    // {hold, w_enable, w_ctrl_enable, jump_en, flush}
    localparam logic [4:0] C_NONE = 5'b00000, C_HOLD = 5'b10000,
                           C_WR = 5'b11100, C_JMP = 5'b10011;
    localparam logic [W-1:0] MC_EC = 32'h0000_000B, MC_EB = 32'h0000_0003,
                             MC_EX = 32'h8000_000B, MC_TM = 32'h8000_0007;

    vec_t             vq[$];
    logic [OUT_W-1:0] exp_q[$];
    int               n_checks = 0;
    int               n_fail = 0;

    function automatic void add(string nm, logic r, logic [4:0] req,
                                logic [W-1:0] pc, ms, mepc, mtvec, mie, logic [4:0] ctl,
                                logic [W-1:0] wms, wmepc, wmie, jaddr, mc);
        vec_t v;
        v.name = nm; v.rst = r; v.req = req;
        v.pc = pc; v.ms = ms; v.mepc = mepc; v.mtvec = mtvec; v.mie = mie;
        {v.exp.hold, v.exp.wen, v.exp.wctrl, v.exp.jump, v.exp.flush} = ctl;
        v.exp.wms = wms; v.exp.wmepc = wmepc; v.exp.wmie = wmie;
        v.exp.jaddr = jaddr; v.exp.mc = mc;
        vq.push_back(v);
    endfunction

    function automatic out_t cur_out();
        out_t o;
        o.hold = hold_o; o.wen = w_enable_o; o.wctrl = w_ctrl_enable_o;
        o.jump = jump_en_o; o.flush = flush_o;
        o.wms = w_mstatus_o; o.wmepc = w_mepc_o; o.wmie = w_mie_o;
        o.jaddr = jump_addr_o; o.mc = mcause_o;
        return o;
    endfunction

    // scoreboard compare
    task automatic check(string nm, out_t act, out_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got ctl=%b wms=%h wmepc=%h wmie=%h jaddr=%h mcause=%h ; want ctl=%b wms=%h wmepc=%h wmie=%h jaddr=%h mcause=%h",
                     nm, {act.hold, act.wen, act.wctrl, act.jump, act.flush},
                     act.wms, act.wmepc, act.wmie, act.jaddr, act.mc,
                     {exp.hold, exp.wen, exp.wctrl, exp.jump, exp.flush},
                     exp.wms, exp.wmepc, exp.wmie, exp.jaddr, exp.mc);
        end
    endtask

    task automatic check_bits(string nm, logic [3:0] act, logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // driver: inputs change 1 time unit after the rising edge, outputs sampled on the falling edge
    task automatic apply(vec_t v);
        out_t e;
        @(posedge clk);
        #1;
        rst = v.rst;
        {ecall_i, ebreak_i, mret_i, ext_int_i, timer_int_i} = v.req;
        pc_i = v.pc; r_mstatus_i = v.ms; r_mepc_i = v.mepc;
        r_mtvec_i = v.mtvec; r_mie_i = v.mie;
        exp_q.push_back(v.exp);
        @(negedge clk);
        e = out_t'(exp_q.pop_front());
        check(v.name, cur_out(), e);
    endtask

    initial begin
        vec_t v;
        // ecall from reset: first edge after release samples the request
        add("rst_hold",    1, R_EC, 32'h100, 32'h08, 32'h000, 32'h201, 32'h880, C_NONE, 0, 0, 0, 0, 0);
        add("ecall_acc",   0, R_EC, 32'h100, 32'h08, 32'h000, 32'h201, 32'h880, C_HOLD, 0, 0, 0, 0, 0);
        add("ecall_save",  0, R0,   32'h104, 32'h08, 32'h000, 32'h201, 32'h880, C_WR, 32'h80, 32'h100, 32'h880, 0, MC_EC);
        add("ecall_jump",  0, R0,   32'h104, 32'h80, 32'h100, 32'h201, 32'h880, C_JMP, 0, 0, 0, 32'h200, MC_EC);
        add("ecall_idle",  0, R0,   32'h200, 32'h80, 32'h100, 32'h201, 32'h880, C_NONE, 0, 0, 0, 0, MC_EC);
        // mret
        add("mret_acc",    0, R_MR, 32'h204, 32'h80, 32'h104, 32'h201, 32'h880, C_HOLD, 0, 0, 0, 0, MC_EC);
        add("mret_rest",   0, R0,   32'h208, 32'h80, 32'h104, 32'h201, 32'h880, C_WR, 32'h88, 32'h104, 32'h880, 0, MC_EC);
        add("mret_jump",   0, R0,   32'h208, 32'h88, 32'h104, 32'h201, 32'h880, C_JMP, 0, 0, 0, 32'h104, MC_EC);
        add("mret_idle",   0, R0,   32'h104, 32'h88, 32'h104, 32'h201, 32'h880, C_NONE, 0, 0, 0, 0, MC_EC);
        // external interrupt gating
        add("ext_mstat0",  0, R_EX, 32'h300, 32'h00, 32'h104, 32'h201, 32'h800, C_NONE, 0, 0, 0, 0, MC_EC);
        add("ext_mie0",    0, R_EX, 32'h300, 32'h08, 32'h104, 32'h201, 32'h080, C_NONE, 0, 0, 0, 0, MC_EC);
        add("ext_acc",     0, R_EX, 32'h300, 32'h08, 32'h104, 32'h201, 32'h800, C_HOLD, 0, 0, 0, 0, MC_EC);
        add("ext_save",    0, R_EX, 32'h304, 32'h08, 32'h104, 32'h201, 32'h800, C_WR, 32'h80, 32'h300, 32'h800, 0, MC_EX);
        add("ext_jump",    0, R_EX, 32'h304, 32'h80, 32'h300, 32'h201, 32'h800, C_JMP, 0, 0, 0, 32'h200, MC_EX);
        add("ext_masked",  0, R_EX, 32'h200, 32'h80, 32'h300, 32'h201, 32'h800, C_NONE, 0, 0, 0, 0, MC_EX);
        // timer interrupt
        add("tmr_acc",     0, R_TM, 32'h400, 32'h08, 32'h300, 32'h201, 32'h080, C_HOLD, 0, 0, 0, 0, MC_EX);
        add("tmr_save",    0, R_TM, 32'h404, 32'h08, 32'h300, 32'h201, 32'h080, C_WR, 32'h80, 32'h400, 32'h080, 0, MC_TM);
        add("tmr_jump",    0, R_TM, 32'h404, 32'h80, 32'h400, 32'h201, 32'h080, C_JMP, 0, 0, 0, 32'h200, MC_TM);
        add("tmr_masked",  0, R_TM, 32'h200, 32'h80, 32'h400, 32'h201, 32'h080, C_NONE, 0, 0, 0, 0, MC_TM);
        // ebreak with MIE already clear: MPIE becomes 0
        add("ebrk_acc",    0, R_EB, 32'h500, 32'h80, 32'h400, 32'h201, 32'h080, C_HOLD, 0, 0, 0, 0, MC_TM);
        add("ebrk_save",   0, R0,   32'h504, 32'h80, 32'h400, 32'h201, 32'h080, C_WR, 32'h00, 32'h500, 32'h080, 0, MC_EB);
        add("ebrk_jump",   0, R0,   32'h504, 32'h00, 32'h500, 32'h201, 32'h080, C_JMP, 0, 0, 0, 32'h200, MC_EB);
        add("ebrk_idle",   0, R0,   32'h200, 32'h00, 32'h500, 32'h201, 32'h080, C_NONE, 0, 0, 0, 0, MC_EB);
        // ecall beats both interrupts; interrupts stay pending and are taken once re-enabled
        add("all_acc",     0, R_EC|R_EX|R_TM, 32'h600, 32'h08, 32'h500, 32'h201, 32'h880, C_HOLD, 0, 0, 0, 0, MC_EB);
        add("all_save",    0, R_EX|R_TM, 32'h604, 32'h08, 32'h500, 32'h201, 32'h880, C_WR, 32'h80, 32'h600, 32'h880, 0, MC_EC);
        add("all_jump",    0, R_EX|R_TM, 32'h604, 32'h80, 32'h600, 32'h201, 32'h880, C_JMP, 0, 0, 0, 32'h200, MC_EC);
        add("all_pend1",   0, R_EX|R_TM, 32'h200, 32'h80, 32'h600, 32'h201, 32'h880, C_NONE, 0, 0, 0, 0, MC_EC);
        add("all_pend2",   0, R_EX|R_TM, 32'h200, 32'h80, 32'h600, 32'h201, 32'h880, C_NONE, 0, 0, 0, 0, MC_EC);
        add("pend_acc",    0, R_EX|R_TM, 32'h700, 32'h08, 32'h600, 32'h201, 32'h880, C_HOLD, 0, 0, 0, 0, MC_EC);
        add("pend_save",   0, R_EX|R_TM, 32'h704, 32'h08, 32'h600, 32'h201, 32'h880, C_WR, 32'h80, 32'h700, 32'h880, 0, MC_EX);
        add("pend_jump",   0, R0,   32'h704, 32'h80, 32'h700, 32'h201, 32'h880, C_JMP, 0, 0, 0, 32'h200, MC_EX);
        add("pend_idle",   0, R0,   32'h200, 32'h80, 32'h700, 32'h201, 32'h880, C_NONE, 0, 0, 0, 0, MC_EX);
        // requests during SAVE and JUMP are ignored
        add("ign_acc",     0, R_EC, 32'h800, 32'h08, 32'h700, 32'h201, 32'h880, C_HOLD, 0, 0, 0, 0, MC_EX);
        add("ign_save",    0, R_EB|R_MR, 32'h804, 32'h08, 32'h700, 32'h201, 32'h880, C_WR, 32'h80, 32'h800, 32'h880, 0, MC_EC);
        add("ign_jump",    0, R_MR, 32'h804, 32'h80, 32'h800, 32'h201, 32'h880, C_JMP, 0, 0, 0, 32'h200, MC_EC);
        add("ign_after1",  0, R0,   32'h200, 32'h80, 32'h800, 32'h201, 32'h880, C_NONE, 0, 0, 0, 0, MC_EC);
        add("ign_after2",  0, R0,   32'h200, 32'h80, 32'h800, 32'h201, 32'h880, C_NONE, 0, 0, 0, 0, MC_EC);
        // ebreak beats mret; mtvec low bits masked
        add("eb_mr_acc",   0, R_EB|R_MR, 32'h900, 32'h80, 32'h800, 32'h201, 32'h880, C_HOLD, 0, 0, 0, 0, MC_EC);
        add("eb_mr_save",  0, R0,   32'h904, 32'h80, 32'h800, 32'h201, 32'h880, C_WR, 32'h00, 32'h900, 32'h880, 0, MC_EB);
        add("eb_mr_jump",  0, R0,   32'h904, 32'h00, 32'h900, 32'h1237, 32'h880, C_JMP, 0, 0, 0, 32'h1234, MC_EB);
        add("eb_mr_idle",  0, R0,   32'h1234, 32'h00, 32'h900, 32'h201, 32'h880, C_NONE, 0, 0, 0, 0, MC_EB);
        // mret beats an enabled external interrupt
        add("mr_ex_acc",   0, R_MR|R_EX, 32'hA00, 32'h08, 32'h900, 32'h201, 32'h880, C_HOLD, 0, 0, 0, 0, MC_EB);
        add("mr_ex_rest",  0, R_EX, 32'hA04, 32'h08, 32'h900, 32'h201, 32'h880, C_WR, 32'h80, 32'h900, 32'h880, 0, MC_EB);
        add("mr_ex_jump",  0, R_EX, 32'hA04, 32'h80, 32'h900, 32'h201, 32'h880, C_JMP, 0, 0, 0, 32'h900, MC_EB);
        add("mr_ex_idle",  0, R_EX, 32'h900, 32'h80, 32'h900, 32'h201, 32'h880, C_NONE, 0, 0, 0, 0, MC_EB);
        add("rs_acc",      0, R_EC, 32'hB00, 32'h08, 32'h900, 32'h201, 32'h880, C_HOLD, 0, 0, 0, 0, MC_EB);

        foreach (vq[i]) apply(vq[i]);

        // reset asserted asynchronously in the middle of SAVE
        @(posedge clk);
        #1;
        {ecall_i, ebreak_i, mret_i, ext_int_i, timer_int_i} = R0;
        check_bits("rs_in_save", {w_enable_o, w_ctrl_enable_o, 2'(dbg_state)}, 4'b1101);
        #2;
        rst = 1'b1;
        #1;
        check("rs_abort", cur_out(), '0);
        v = vq[0];
        v.name = "rs_held"; v.rst = 1'b1; v.req = R0; v.exp = '0;
        apply(v);
        v.name = "rs_release"; v.rst = 1'b0;
        apply(v);
        check_bits("rs_state_idle", {2'b00, dbg_state}, 4'h0);
        v.name = "rs_quiet";
        apply(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_trap_ctrl.md
CSR_TRAP_CTRL -- requirements
Module: csr_trap_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, CSR data width.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 pc_i  input  DATA_W  address of the instruction currently in execute.
REQ-005 ecall_i, ebreak_i, mret_i  input  1 each  decoded single-cycle requests from execute.
REQ-006 ext_int_i, timer_int_i  input  1 each  level-sensitive interrupt lines.
REQ-007 r_mstatus_i, r_mepc_i, r_mtvec_i, r_mie_i  input  DATA_W each  current CSR values.
REQ-008 w_enable_o, w_ctrl_enable_o  output  1 each  CSR controller-write strobes.
REQ-009 w_mstatus_o, w_mepc_o, w_mie_o  output  DATA_W each  CSR controller-write data.
REQ-010 hold_o  output  1  pipeline stall request.
REQ-011 flush_o  output  1  pipeline flush pulse.
REQ-012 jump_en_o  output  1  PC redirect strobe; jump_addr_o  output  DATA_W  redirect target.
REQ-013 mcause_o  output  DATA_W  cause of the most recently accepted trap.

Function
REQ-014 The FSM SHALL have states IDLE, SAVE, RESTORE and JUMP.
REQ-015 The FSM SHALL sample requests only in IDLE; requests arriving in any other state SHALL be ignored and SHALL NOT be latched.
REQ-016 Request priority in IDLE SHALL be: ecall > ebreak > mret > external interrupt > timer interrupt.
REQ-017 An external interrupt SHALL qualify only when ext_int_i=1, mstatus[3] (MIE)=1 and mie[11]=1.
REQ-018 A timer interrupt SHALL qualify only when timer_int_i=1, mstatus[3]=1 and mie[7]=1.
REQ-019 On acceptance at cycle T:
- trap (exception or interrupt): pc_i and the cause are captured, and the FSM enters SAVE at T+1;
- mret: the FSM enters RESTORE at T+1.
REQ-020 Cause encodings SHALL be: ecall 0x0000000B, ebreak 0x00000003, external 0x8000000B, timer 0x80000007.
REQ-021 mcause_o SHALL update at T+1 and hold until the next accepted trap; mret SHALL NOT alter it.
REQ-022 In SAVE (one cycle), the block SHALL drive:
- w_enable_o=1 and w_ctrl_enable_o=1;
- w_mepc_o = captured pc;
- w_mstatus_o = r_mstatus_i with bit7 (MPIE) set to bit3 and bit3 (MIE) cleared;
- w_mie_o = r_mie_i.
REQ-023 In RESTORE (one cycle), the block SHALL drive:
- w_enable_o=1 and w_ctrl_enable_o=1;
- w_mstatus_o = r_mstatus_i with bit3 set to bit7 and bit7 set to 1;
- w_mepc_o = r_mepc_i;
- w_mie_o = r_mie_i.
REQ-024 SAVE and RESTORE SHALL each transition unconditionally to JUMP.
REQ-025 In JUMP (one cycle), the block SHALL drive jump_en_o=1 and flush_o=1, with jump_addr_o as follows:
- after SAVE: {r_mtvec_i[DATA_W-1:2], 2'b00};
- after RESTORE: r_mepc_i.
REQ-026 JUMP SHALL return to IDLE; total trap/mret latency SHALL be 3 cycles from acceptance to IDLE.
REQ-027 hold_o SHALL be 1 combinationally in the acceptance cycle and in every non-IDLE state, and 0 otherwise.
REQ-028 All write strobes, jump_en_o and flush_o SHALL be 0 outside their stated states; their data outputs SHALL be 0 when the strobes are 0.
REQ-029 The earliest re-acceptance SHALL be the cycle after JUMP; an interrupt still pending but masked by the cleared MIE SHALL NOT be taken.
REQ-030 Simultaneous ecall and pending interrupt SHALL take ecall; the interrupt SHALL remain pending by level and SHALL NOT be lost.

Reset
REQ-031 While rst=1, the FSM SHALL be IDLE and the captured pc and mcause_o SHALL be 0; all strobes, hold_o and flush_o SHALL be 0.
REQ-032 Assertion of rst mid-sequence (SAVE, RESTORE or JUMP) SHALL abort immediately with no further CSR write or jump.
REQ-033 After rst deasserts, the first request SHALL be sampled on the first rising edge.

Verification
REQ-034 ecall with pc_i=0x100, mtvec=0x201, mstatus=0x8 -> T+1 SAVE writes mepc=0x100 and mstatus=0x80; T+2 jump to 0x200 with flush; mcause_o=0xB.
REQ-035 mret with mepc=0x104, mstatus=0x80 -> T+1 mstatus write=0x88; T+2 jump to 0x104; mcause_o unchanged.
REQ-036 ext_int_i=1, mie=0x800, mstatus=0x0 -> no acceptance and hold_o=0; then set mstatus=0x8 -> trap taken with mcause_o=0x8000000B.
REQ-037 ecall, ext_int_i and timer_int_i all asserted (all enabled) -> ecall taken; interrupt not taken afterwards while MIE=0.
REQ-038 rst asserted during SAVE -> outputs immediately 0; no jump_en_o pulse; FSM in IDLE after release.
REQ-039 mret asserted during JUMP of a prior trap -> ignored; exactly one jump observed.
